// File: rtl/alu_pkg.sv
// Shared definitions for the ALU request/response slice.
// Contents: opcode encodings, default widths, and the response-entry record
// (default-width view) returned to the issuing engine.
package alu_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_TAG_W  = 4;

  localparam logic [4:0] OP_ADD = 5'b00000;
  localparam logic [4:0] OP_SUB = 5'b00001;
  localparam logic [4:0] OP_AND = 5'b00010;
  localparam logic [4:0] OP_OR  = 5'b00011;
  localparam logic [4:0] OP_SLL = 5'b00100;
  localparam logic [4:0] OP_SRA = 5'b00101;

  typedef struct packed {
    logic [DEF_DATA_W-1:0] result;
    logic                  isNotEqual;
    logic                  isLessThan;
    logic                  overflow;
    logic [DEF_TAG_W-1:0]  tag;
  } rsp_entry_t;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU evaluation.
// Ports:
//   i_opcode  - operation select (alu_pkg OP_*), unknown codes give 0
//   i_shamt   - shift amount, used by sll/sra only
//   i_a, i_b  - operands
//   o_result  - operation result (modulo 2^DATA_W)
//   o_ne      - A != B
//   o_lt      - signed A < B (overflow-corrected)
//   o_ovf     - signed overflow of add/sub, 0 otherwise
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic [4:0]        i_opcode,
  input  logic [4:0]        i_shamt,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [DATA_W-1:0] o_result,
  output logic              o_ne,
  output logic              o_lt,
  output logic              o_ovf
);

  logic [DATA_W-1:0] w_sum;
  logic [DATA_W-1:0] w_diff;
  logic              w_add_ovf;
  logic              w_sub_ovf;

  assign w_sum  = i_a + i_b;
  assign w_diff = i_a - i_b;

  assign w_add_ovf = (i_a[DATA_W-1] == i_b[DATA_W-1]) && (w_sum[DATA_W-1]  != i_a[DATA_W-1]);
  assign w_sub_ovf = (i_a[DATA_W-1] != i_b[DATA_W-1]) && (w_diff[DATA_W-1] != i_a[DATA_W-1]);

  // Flags come from the subtraction regardless of opcode; the XOR with the
  // subtract overflow keeps the signed compare correct when A-B wraps.
  assign o_ne = (w_diff != '0);
  assign o_lt = w_diff[DATA_W-1] ^ w_sub_ovf;

  always_comb begin
    o_result = '0;
    o_ovf    = 1'b0;
    case (i_opcode)
      OP_ADD: begin
        o_result = w_sum;
        o_ovf    = w_add_ovf;
      end
      OP_SUB: begin
        o_result = w_diff;
        o_ovf    = w_sub_ovf;
      end
      OP_AND:  o_result = i_a & i_b;
      OP_OR:   o_result = i_a | i_b;
      OP_SLL:  o_result = i_a << i_shamt;
      OP_SRA:  o_result = $unsigned($signed(i_a) >>> i_shamt);
      default: o_result = '0;
    endcase
  end

endmodule

// File: rtl/alu_req_rsp.sv
// Request/response front-end for the ALU core.
// Tagged requests are accepted over req_valid/req_ready, evaluated by
// alu_core and written into an in-order response buffer, which is drained
// over rsp_valid/rsp_ready. Also counts accepted overflowing operations
// (saturating).
// Ports:
//   clock, reset           - single clock, synchronous active-high reset
//   req_*                  - request channel (opcode, shift amount, operands, tag)
//   rsp_*                  - response channel (result, flags, tag); zero when empty
//   ovf_count              - saturating count of accepted ops with overflow=1
//   busy                   - response buffer holds at least one entry
module alu_req_rsp
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned TAG_W  = DEF_TAG_W,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [4:0]        req_opcode,
  input  logic [4:0]        req_shiftamt,
  input  logic [DATA_W-1:0] req_operandA,
  input  logic [DATA_W-1:0] req_operandB,
  input  logic [TAG_W-1:0]  req_tag,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_isNotEqual,
  output logic              rsp_isLessThan,
  output logic              rsp_overflow,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic [CNT_W-1:0]  ovf_count,
  output logic              busy
);

  localparam int unsigned PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LVL_W    = $clog2(DEPTH + 1);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic              isNotEqual;
    logic              isLessThan;
    logic              overflow;
    logic [TAG_W-1:0]  tag;
  } entry_t;

  entry_t             r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [LVL_W-1:0]   r_count;
  logic [CNT_W-1:0]   r_ovf_count;

  logic [DATA_W-1:0]  w_result;
  logic               w_ne;
  logic               w_lt;
  logic               w_ovf;
  logic               w_push;
  logic               w_pop;
  entry_t             w_entry;
  entry_t             w_head;

  alu_core #(.DATA_W(DATA_W)) u_core (
    .i_opcode (req_opcode),
    .i_shamt  (req_shiftamt),
    .i_a      (req_operandA),
    .i_b      (req_operandB),
    .o_result (w_result),
    .o_ne     (w_ne),
    .o_lt     (w_lt),
    .o_ovf    (w_ovf)
  );

  assign req_ready = !reset && (r_count < FULL_LVL);
  assign rsp_valid = (r_count != '0);
  assign busy      = (r_count != '0);
  assign w_push    = req_valid && req_ready;
  assign w_pop     = rsp_valid && rsp_ready;
  assign ovf_count = r_ovf_count;

  always_comb begin
    w_entry.result     = w_result;
    w_entry.isNotEqual = w_ne;
    w_entry.isLessThan = w_lt;
    w_entry.overflow   = w_ovf;
    w_entry.tag        = req_tag;
    // Storage is not cleared on reset; masking with rsp_valid keeps the
    // response outputs at zero whenever the buffer is empty.
    w_head = '0;
    if (rsp_valid) begin
      w_head = r_mem[r_rd_ptr];
    end
  end

  assign rsp_result     = w_head.result;
  assign rsp_isNotEqual = w_head.isNotEqual;
  assign rsp_isLessThan = w_head.isLessThan;
  assign rsp_overflow   = w_head.overflow;
  assign rsp_tag        = w_head.tag;

  // req_ready is low during reset, so no write can land while resetting.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_entry;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_ovf_count <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + LVL_W'(1);
        2'b01:   r_count <= r_count - LVL_W'(1);
        default: r_count <= r_count;
      endcase
      if (w_push && w_ovf && (r_ovf_count != '1)) begin
        r_ovf_count <= r_ovf_count + CNT_W'(1);
      end
    end
  end

endmodule
